// File: rtl/wb_pkg.sv
// Shared types and default sizes for the register writeback queue.
// No logic; a queue entry is one pending register-file write (addr, data).
package wb_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 5;
    localparam int DEPTH_DEF  = 4;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer with two ordered push slots and one pop per cycle; entries exposed for lookup.
// Latency: a push is visible at the head/entries one cycle later.
// Backpressure: none internally; the caller must keep pushes within free space.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [1:0]             push_cnt,
    input  wb_entry_t              push0_dat,
    input  wb_entry_t              push1_dat,
    input  logic                   pop,
    output logic [PTR_W-1:0]       head,
    output logic [CNT_W-1:0]       count,
    output wb_entry_t [DEPTH-1:0]  entries
);

    wb_entry_t [DEPTH-1:0] mem_q, mem_d;
    logic [PTR_W-1:0]      head_q, head_d;
    logic [PTR_W-1:0]      tail_q, tail_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [PTR_W-1:0]      tail_p1;

    // push0 is always the older entry and lands at the tail.
    always_comb begin
        mem_d   = mem_q;
        tail_p1 = tail_q + PTR_W'(1);
        if (push_cnt != 2'd0) begin
            mem_d[tail_q] = push0_dat;
        end
        if (push_cnt == 2'd2) begin
            mem_d[tail_p1] = push1_dat;
        end
        head_d  = head_q + PTR_W'(pop);
        tail_d  = tail_q + PTR_W'(push_cnt);
        count_d = count_q + CNT_W'(push_cnt) - CNT_W'(pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign head    = head_q;
    assign count   = count_q;
    assign entries = mem_q;

endmodule

// File: rtl/reg_writeback.sv
// Writeback queue owning the register-file write port; merges ALU and load results in order.
// Latency: accepted result drives rf_write_* one cycle later when the queue is empty; one drain per cycle.
// Backpressure: in_ready drops when fewer than two slots are free; REG_WRITEBACK_FORWARD_EN enables rsN_fwd.
module reg_writeback
    import wb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_rd,
    input  logic [DATA_W-1:0] ld_data,
    output logic              in_ready,
    output logic              rf_write_enable,
    output logic [ADDR_W-1:0] rf_write_addr,
    output logic [DATA_W-1:0] rf_write_data,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic              rs1_busy,
    output logic              rs2_busy,
    output logic [DATA_W-1:0] rs1_fwd,
    output logic [DATA_W-1:0] rs2_fwd
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]      head;
    logic [CNT_W-1:0]      count;
    wb_entry_t [DEPTH-1:0] entries;
    wb_entry_t             head_ent;
    wb_entry_t             push0_dat, push1_dat;
    logic [1:0]            push_cnt;
    logic                  ld_push, alu_push, pop;

    assign in_ready = (count <= CNT_W'(DEPTH - 2));

    // x0 results complete the handshake but never occupy a slot.
    assign ld_push  = ld_valid  && in_ready && (ld_rd  != '0);
    assign alu_push = alu_valid && in_ready && (alu_rd != '0);
    assign pop      = (count != '0);

    always_comb begin
        push0_dat = '0;
        push1_dat = '0;
        push_cnt  = 2'd0;
        if (ld_push) begin
            push0_dat = '{addr: ld_rd, data: ld_data};
            push1_dat = '{addr: alu_rd, data: alu_data};
            push_cnt  = alu_push ? 2'd2 : 2'd1;
        end else if (alu_push) begin
            push0_dat = '{addr: alu_rd, data: alu_data};
            push_cnt  = 2'd1;
        end
    end

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push_cnt  (push_cnt),
        .push0_dat (push0_dat),
        .push1_dat (push1_dat),
        .pop       (pop),
        .head      (head),
        .count     (count),
        .entries   (entries)
    );

    assign head_ent        = entries[head];
    assign rf_write_enable = pop;
    assign rf_write_addr   = pop ? head_ent.addr : '0;
    assign rf_write_data   = pop ? head_ent.data : '0;

    // Walk oldest to youngest so the last match, the youngest, wins.
    always_comb begin
        logic [PTR_W-1:0] idx;
        rs1_busy = 1'b0;
        rs2_busy = 1'b0;
        rs1_fwd  = '0;
        rs2_fwd  = '0;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if (CNT_W'(i) < count) begin
                if ((rs1_addr != '0) && (entries[idx].addr == rs1_addr)) begin
                    rs1_busy = 1'b1;
`ifdef REG_WRITEBACK_FORWARD_EN
                    rs1_fwd  = entries[idx].data;
`endif
                end
                if ((rs2_addr != '0) && (entries[idx].addr == rs2_addr)) begin
                    rs2_busy = 1'b1;
`ifdef REG_WRITEBACK_FORWARD_EN
                    rs2_fwd  = entries[idx].data;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_reg_writeback.sv
// Directed cycle-by-cycle vectors for reg_writeback plus a mid-operation reset sequence.
module tb_reg_writeback;

    logic       clk = 1'b0;
    logic       reset;
    logic       alu_valid, ld_valid;
    logic [4:0] alu_rd, ld_rd;
    logic [7:0] alu_data, ld_data;
    logic       in_ready, rf_write_enable;
    logic [4:0] rf_write_addr;
    logic [7:0] rf_write_data;
    logic [4:0] rs1_addr, rs2_addr;
    logic       rs1_busy, rs2_busy;
    logic [7:0] rs1_fwd, rs2_fwd;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    reg_writeback dut (
        .clk             (clk),
        .reset           (reset),
        .alu_valid       (alu_valid),
        .alu_rd          (alu_rd),
        .alu_data        (alu_data),
        .ld_valid        (ld_valid),
        .ld_rd           (ld_rd),
        .ld_data         (ld_data),
        .in_ready        (in_ready),
        .rf_write_enable (rf_write_enable),
        .rf_write_addr   (rf_write_addr),
        .rf_write_data   (rf_write_data),
        .rs1_addr        (rs1_addr),
        .rs2_addr        (rs2_addr),
        .rs1_busy        (rs1_busy),
        .rs2_busy        (rs2_busy),
        .rs1_fwd         (rs1_fwd),
        .rs2_fwd         (rs2_fwd)
    );

    typedef struct {
        logic       lv;
        logic [4:0] lrd;
        logic [7:0] ld;
        logic       av;
        logic [4:0] ard;
        logic [7:0] ad;
        logic [4:0] r1;
        logic [4:0] r2;
        logic       rdy;
        logic       we;
        logic [4:0] wa;
        logic [7:0] wd;
        logic       b1;
        logic [7:0] f1;
        logic       b2;
        logic [7:0] f2;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(int lv, int lrd, int ld, int av, int ard, int ad, int r1, int r2,
                                int rdy, int we, int wa, int wd, int b1, int f1, int b2, int f2);
        vec_t v;
        v.lv = 1'(lv);  v.lrd = 5'(lrd); v.ld = 8'(ld);
        v.av = 1'(av);  v.ard = 5'(ard); v.ad = 8'(ad);
        v.r1 = 5'(r1);  v.r2 = 5'(r2);
        v.rdy = 1'(rdy); v.we = 1'(we); v.wa = 5'(wa); v.wd = 8'(wd);
        v.b1 = 1'(b1);  v.f1 = 8'(f1);  v.b2 = 1'(b2);  v.f2 = 8'(f2);
        return v;
    endfunction

    // Forwarded data is only produced when the forwarding build is selected.
    function automatic logic [7:0] fwd_exp(logic [7:0] f);
`ifdef REG_WRITEBACK_FORWARD_EN
        return f;
`else
        return (f == 8'h00) ? 8'h00 : 8'h00;
`endif
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(logic lv, logic [4:0] lrd, logic [7:0] ld,
                         logic av, logic [4:0] ard, logic [7:0] ad,
                         logic [4:0] r1, logic [4:0] r2);
        ld_valid = lv;  ld_rd = lrd;  ld_data = ld;
        alu_valid = av; alu_rd = ard; alu_data = ad;
        rs1_addr = r1;  rs2_addr = r2;
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 5'd0, 8'h00, 1'b0, 5'd0, 8'h00, 5'd5, 5'd5);

        //        lv lrd ld    av ard ad    r1 r2 | rdy we wa wd    b1 f1    b2 f2
        vecs.push_back(mk(0, 0, 'h00, 0, 0, 'h00, 5, 5,  1, 0, 0, 'h00, 0, 'h00, 0, 'h00));
        vecs.push_back(mk(0, 0, 'h00, 1, 5, 'h3C, 5, 0,  1, 0, 0, 'h00, 0, 'h00, 0, 'h00));
        vecs.push_back(mk(0, 0, 'h00, 0, 0, 'h00, 5, 0,  1, 1, 5, 'h3C, 1, 'h3C, 0, 'h00));
        vecs.push_back(mk(0, 0, 'h00, 0, 0, 'h00, 5, 0,  1, 0, 0, 'h00, 0, 'h00, 0, 'h00));
        vecs.push_back(mk(1, 6, 'h11, 1, 7, 'h22, 0, 0,  1, 0, 0, 'h00, 0, 'h00, 0, 'h00));
        vecs.push_back(mk(0, 0, 'h00, 0, 0, 'h00, 6, 7,  1, 1, 6, 'h11, 1, 'h11, 1, 'h22));
        vecs.push_back(mk(0, 0, 'h00, 0, 0, 'h00, 6, 7,  1, 1, 7, 'h22, 0, 'h00, 1, 'h22));
        vecs.push_back(mk(0, 0, 'h00, 1, 0, 'hFF, 0, 0,  1, 0, 0, 'h00, 0, 'h00, 0, 'h00));
        vecs.push_back(mk(0, 0, 'h00, 0, 0, 'h00, 0, 0,  1, 0, 0, 'h00, 0, 'h00, 0, 'h00));
        vecs.push_back(mk(1, 1, 'h01, 1, 2, 'h02, 0, 0,  1, 0, 0, 'h00, 0, 'h00, 0, 'h00));
        vecs.push_back(mk(1, 3, 'h03, 1, 4, 'h04, 1, 2,  1, 1, 1, 'h01, 1, 'h01, 1, 'h02));
        vecs.push_back(mk(1, 5, 'h05, 1, 6, 'h06, 3, 1,  0, 1, 2, 'h02, 1, 'h03, 0, 'h00));
        vecs.push_back(mk(1, 5, 'h05, 1, 6, 'h06, 3, 4,  1, 1, 3, 'h03, 1, 'h03, 1, 'h04));
        vecs.push_back(mk(0, 0, 'h00, 0, 0, 'h00, 6, 5,  0, 1, 4, 'h04, 1, 'h06, 1, 'h05));
        vecs.push_back(mk(0, 0, 'h00, 0, 0, 'h00, 6, 4,  1, 1, 5, 'h05, 1, 'h06, 0, 'h00));
        vecs.push_back(mk(0, 0, 'h00, 0, 0, 'h00, 6, 5,  1, 1, 6, 'h06, 1, 'h06, 0, 'h00));
        vecs.push_back(mk(0, 0, 'h00, 0, 0, 'h00, 6, 0,  1, 0, 0, 'h00, 0, 'h00, 0, 'h00));
        vecs.push_back(mk(1, 3, 'hA0, 1, 3, 'hB0, 3, 0,  1, 0, 0, 'h00, 0, 'h00, 0, 'h00));
        vecs.push_back(mk(0, 0, 'h00, 0, 0, 'h00, 3, 3,  1, 1, 3, 'hA0, 1, 'hB0, 1, 'hB0));
        vecs.push_back(mk(0, 0, 'h00, 0, 0, 'h00, 3, 0,  1, 1, 3, 'hB0, 1, 'hB0, 0, 'h00));
        vecs.push_back(mk(1, 0, 'h77, 1, 9, 'h99, 9, 0,  1, 0, 0, 'h00, 0, 'h00, 0, 'h00));
        vecs.push_back(mk(0, 0, 'h00, 0, 0, 'h00, 9, 0,  1, 1, 9, 'h99, 1, 'h99, 0, 'h00));
        vecs.push_back(mk(0, 0, 'h00, 0, 0, 'h00, 9, 0,  1, 0, 0, 'h00, 0, 'h00, 0, 'h00));

        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            vec_t v;
            v = vecs[i];
            drive(v.lv, v.lrd, v.ld, v.av, v.ard, v.ad, v.r1, v.r2);
            #1;
            chk($sformatf("row%0d_in_ready", i), 32'(in_ready),        32'(v.rdy));
            chk($sformatf("row%0d_we", i),       32'(rf_write_enable), 32'(v.we));
            chk($sformatf("row%0d_waddr", i),    32'(rf_write_addr),   32'(v.wa));
            chk($sformatf("row%0d_wdata", i),    32'(rf_write_data),   32'(v.wd));
            chk($sformatf("row%0d_rs1_busy", i), 32'(rs1_busy),        32'(v.b1));
            chk($sformatf("row%0d_rs2_busy", i), 32'(rs2_busy),        32'(v.b2));
            chk($sformatf("row%0d_rs1_fwd", i),  32'(rs1_fwd),         32'(fwd_exp(v.f1)));
            chk($sformatf("row%0d_rs2_fwd", i),  32'(rs2_fwd),         32'(fwd_exp(v.f2)));
            @(negedge clk);
        end

        // Fill to three entries, then reset mid-operation.
        drive(1'b1, 5'd10, 8'h10, 1'b1, 5'd11, 8'h11, 5'd0, 5'd0);
        @(negedge clk);
        drive(1'b1, 5'd12, 8'h12, 1'b1, 5'd13, 8'h13, 5'd0, 5'd0);
        @(negedge clk);
        drive(1'b0, 5'd0, 8'h00, 1'b0, 5'd0, 8'h00, 5'd13, 5'd12);
        #1;
        chk("pre_rst_in_ready", 32'(in_ready),        32'd0);
        chk("pre_rst_we",       32'(rf_write_enable), 32'd1);
        chk("pre_rst_waddr",    32'(rf_write_addr),   32'd11);
        chk("pre_rst_rs1_busy", 32'(rs1_busy),        32'd1);
        chk("pre_rst_rs1_fwd",  32'(rs1_fwd),         32'(fwd_exp(8'h13)));
        reset = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_we",       32'(rf_write_enable), 32'd0);
        chk("rst_in_ready", 32'(in_ready),        32'd1);
        chk("rst_waddr",    32'(rf_write_addr),   32'd0);
        chk("rst_wdata",    32'(rf_write_data),   32'd0);
        chk("rst_rs1_busy", 32'(rs1_busy),        32'd0);
        chk("rst_rs2_busy", 32'(rs2_busy),        32'd0);
        chk("rst_rs1_fwd",  32'(rs1_fwd),         32'd0);
        reset = 1'b0;
        @(negedge clk);
        #1;
        chk("post_rst_we",       32'(rf_write_enable), 32'd0);
        chk("post_rst_in_ready", 32'(in_ready),        32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
